// File: rtl/runtime_ctr_ctrl_pkg.sv
// Shared types for the runtime counter sequencer: state encoding, result
// layout and the saturating drop-counter helper.
package runtime_ctr_ctrl_pkg;

    typedef logic [31:0] word_type;

    localparam int RTC_DROP_WIDTH = 16;
    localparam int RTC_OP_WIDTH   = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT,
        CAPTURE
    } rtc_state_type;

    // Layout of one stored result at the default opcode width; the FIFO
    // stores the same field order {op, cycles, timeout} as a flat vector.
    typedef struct packed {
        logic [RTC_OP_WIDTH-1:0] op;
        word_type                cycles;
        logic                    timeout;
    } rtc_result_type;

    // Adds 0..2 to the drop counter, clamping at all-ones.
    function automatic logic [RTC_DROP_WIDTH-1:0] rtc_sat_add(
        input logic [RTC_DROP_WIDTH-1:0] a,
        input logic [1:0]                inc
    );
        logic [RTC_DROP_WIDTH:0] sum;
        sum = {1'b0, a} + {{(RTC_DROP_WIDTH-1){1'b0}}, inc};
        return sum[RTC_DROP_WIDTH] ? '1 : sum[RTC_DROP_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/runtime_ctr_ctrl_fifo.sv
// Show-ahead synchronous FIFO for measurement results. Head data is visible
// while not empty; push is accepted when full only if a pop happens in the
// same cycle.
module rtc_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 41
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/runtime_ctr_ctrl.sv
// Per-instruction latency sequencer around one runtime_ctr: arms it on an
// accepted issue, forwards synch, waits out the counter lag and stores
// {opcode, cycles, timeout} into a small result FIFO.
// Optional RUN-state timeout: define RUNTIME_CTR_CTRL_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for an issue strobe without synch
// RUN     | counter armed, waiting for synch (or timeout)
// WAIT    | one cycle of runtime_ctr output lag
// CAPTURE | ctr_val valid; write result or count a drop
module runtime_ctr_ctrl
    import runtime_ctr_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int OP_WIDTH       = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_en,
    input  logic [OP_WIDTH-1:0]       instr_op,
    input  logic                      synch,
    output logic                      ctr_instr_en,
    output logic                      ctr_synch,
    input  word_type                  ctr_val,
    output logic                      res_valid,
    input  logic                      res_ready,
    output word_type                  res_cycles,
    output logic [OP_WIDTH-1:0]       res_op,
    output logic                      res_timeout,
    output logic                      busy,
    output logic [RTC_DROP_WIDTH-1:0] drop_cnt
);

    localparam int RES_W = OP_WIDTH + 33;

    rtc_state_type       state;
    rtc_state_type       state_next;
    logic [OP_WIDTH-1:0] op_q;
    logic                timeout_q;
    logic                timeout_hit;
    logic                accept;
    logic                capture;
    logic                pop;
    logic                fifo_empty;
    logic                fifo_full;
    logic                drop_issue;
    logic                drop_result;
    logic [RES_W-1:0]    head;
    logic [OP_WIDTH-1:0] head_op;
    word_type            head_cycles;
    logic                head_timeout;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and strobes to runtime_ctr.
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        capture      = 1'b0;
        ctr_instr_en = 1'b0;
        ctr_synch    = 1'b0;
        case (state)
            IDLE: begin
                accept       = instr_en & ~synch;
                ctr_instr_en = accept;
                if (accept) state_next = RUN;
            end
            RUN: begin
                ctr_synch = synch | timeout_hit;
                if (synch | timeout_hit) state_next = WAIT;
            end
            WAIT:    state_next = CAPTURE;
            CAPTURE: begin
                capture    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Opcode of the instruction being measured.
    always_ff @(posedge clk) begin
        if (rst)         op_q <= '0;
        else if (accept) op_q <= instr_op;
    end

`ifdef RUNTIME_CTR_CTRL_TIMEOUT_EN
    word_type timer;

    // Timer holds cycles elapsed since the issue, so a timeout result reports
    // the same count runtime_ctr accumulates (TIMEOUT_CYCLES-1).
    always_ff @(posedge clk) begin
        if (rst)               timer <= '0;
        else if (accept)       timer <= 32'd1;
        else if (state == RUN) timer <= timer + 32'd1;
    end

    assign timeout_hit = (state == RUN) & (timer == 32'(TIMEOUT_CYCLES - 1)) & ~synch;

    // Sticky flag marking the current measurement as ended by timeout.
    always_ff @(posedge clk) begin
        if (rst)              timeout_q <= 1'b0;
        else if (accept)      timeout_q <= 1'b0;
        else if (timeout_hit) timeout_q <= 1'b1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
    assign timeout_q          = 1'b0;
`endif

    assign pop = res_valid & res_ready;

    rtc_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RES_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .wdata ({op_q, ctr_val, timeout_q}),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign {head_op, head_cycles, head_timeout} = head;
    assign res_valid   = ~fifo_empty;
    assign res_op      = res_valid ? head_op : '0;
    assign res_cycles  = res_valid ? head_cycles : '0;
    assign res_timeout = res_valid & head_timeout;

    // A full FIFO that pops in the same cycle still takes the result.
    assign drop_issue  = instr_en & (state != IDLE);
    assign drop_result = capture & fifo_full & ~pop;

    // Saturating drop counter; one cycle may add two.
    always_ff @(posedge clk) begin
        if (rst) drop_cnt <= '0;
        else     drop_cnt <= rtc_sat_add(drop_cnt, {1'b0, drop_issue} + {1'b0, drop_result});
    end

endmodule

// File: doc/runtime_ctr_ctrl.md
Name: runtime_ctr_ctrl

Overview:
- Sequences one runtime_ctr instance to measure per-instruction latency, from instruction issue to pipeline synch.
- Arms the counter on an accepted issue, forwards synch, and waits out the counter's output lag.
- Captures the measured cycle count with the instruction opcode into a small result FIFO, drained by the host/debug interface via valid/ready.
- Sits between the control unit (issue/synch strobes) and the runtime counter.

Parameters:
- FIFO_DEPTH, 4, result FIFO entries; power of two, >=2.
- OP_WIDTH, 8, opcode width tagged onto each result.
- TIMEOUT_CYCLES, 1024, RUN-state cycle limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_en  in  1  instruction issue strobe
- instr_op  in  OP_WIDTH  opcode, valid with instr_en
- synch  in  1  pipeline synchronised strobe
- ctr_instr_en  out  1  to runtime_ctr instr_en
- ctr_synch  out  1  to runtime_ctr synch
- ctr_val  in  word_type (32)  from runtime_ctr
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer accepts head
- res_cycles  out  word_type  measured cycles
- res_op  out  OP_WIDTH  opcode of measured instruction
- res_timeout  out  1  entry ended by timeout
- busy  out  1  state != IDLE
- drop_cnt  out  16  saturating count of dropped issues/results

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst; all state updates on posedge clk.
- Reset values: state IDLE, FIFO empty, res_valid=0, res_cycles=0, res_op=0, res_timeout=0, ctr_instr_en=0, ctr_synch=0, busy=0, drop_cnt=0, timer=0. Reset mid-measurement abandons it; no FIFO entry is written.
- Counter outputs are combinational from state and inputs:
  - ctr_instr_en = (state==IDLE) & instr_en & ~synch.
  - ctr_synch = (state==RUN) & (synch | timeout_hit).
  - Hence runtime_ctr sees exactly one arm strobe and one stop strobe per measurement.
- States: IDLE, RUN, WAIT, CAPTURE.
  - IDLE: instr_en & ~synch -> latch instr_op into op_q, go RUN. instr_en & synch -> ignored, stay IDLE, no drop counted.
  - RUN: synch (or timeout_hit) -> WAIT. instr_en in RUN (including same cycle as synch) -> drop_cnt+1 and the opcode is discarded.
  - WAIT: one cycle unconditionally -> CAPTURE. instr_en here -> drop_cnt+1.
  - CAPTURE: if FIFO not full, write {op_q, ctr_val, timeout_q}; else drop_cnt+1 and the result is discarded. Go IDLE. instr_en here -> drop_cnt+1.
  - A single cycle with both a dropped issue and a dropped result adds 2.
- Timing: issue at cycle T, synch at cycle T+N gives res_cycles=N, written at CAPTURE (cycle T+N+2). res_valid rises at T+N+3. Next issue can be accepted at T+N+3.
- FIFO:
  - Show-ahead: res_* reflect the head while res_valid=1.
  - Pop on res_valid & res_ready. Outputs must hold stable while res_valid & ~res_ready.
  - Write and pop in the same cycle are allowed when full; this is not a drop.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- drop_cnt saturates at 16'hFFFF.
- busy=1 in RUN, WAIT and CAPTURE.

Optional Feature:
- RUNTIME_CTR_CTRL_TIMEOUT_EN defined:
  - A 32-bit timer clears on entry to RUN and increments each RUN cycle.
  - timeout_hit = (state==RUN) & (timer==TIMEOUT_CYCLES-1) & ~synch.
  - timeout_hit forces ctr_synch and sets timeout_q. The result has res_timeout=1 and res_cycles=TIMEOUT_CYCLES-1.
  - timeout_q clears on entry to RUN.
- Not defined: no timer logic, timeout_hit=0, res_timeout tied 0, TIMEOUT_CYCLES unused.

Decomposition:
- tpu_pkg additions:
  - rtc_state_type enum {IDLE, RUN, WAIT, CAPTURE}.
  - rtc_result_type packed struct {op, cycles (word_type), timeout}.
  - RTC_DROP_WIDTH=16.
- Sub-module rtc_result_fifo: parameterised synchronous show-ahead FIFO of rtc_result_type, with full/empty flags and simultaneous push/pop.

Test Plan:
- instr_en op=0x21 at cycle 10, synch at cycle 17 -> ctr_instr_en pulse at 10, ctr_synch pulse at 17; res_valid at 20 with res_cycles=7, res_op=0x21, res_timeout=0.
- Five measurements (N=3,4,5,6,7) with res_ready=0 -> first four stored, fifth dropped, drop_cnt=1; draining with res_ready=1 yields 3,4,5,6 in order, then res_valid=0.
- instr_en in RUN cycle 12 and together with synch at cycle 17 -> drop_cnt=2, single result N=7; instr_en&synch in IDLE -> no arm, drop_cnt unchanged.
- rst asserted in WAIT -> next cycle IDLE, FIFO empty, drop_cnt=0, no result appears; a fresh issue measures correctly.
- With RUNTIME_CTR_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16, issue with no synch -> ctr_synch at issue+15; result res_cycles=15, res_timeout=1. Late synch after that -> ignored.
- FIFO full with res_ready=1 while CAPTURE writes -> push and pop both occur, no drop, order preserved.
